// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: load/store size codes, the IO
// window select bits and the transaction state machine encoding, plus a
// helper that turns a size code into a byte count.
package mem_arbiter_pkg;

  // ls_size encodings; 2'b10 and 2'b11 both mean a 32-bit word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // An address with addr[IO_BIT+1:IO_BIT] == IO_SEL targets the IO buffer
  // and is throttled by io_full.
  localparam int         IO_BIT = 16;
  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Number of bytes moved for a data access of the given size.
  function automatic logic [4:0] size_len(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_len = 5'd1;
      SZ_HALF: size_len = 5'd2;
      default: size_len = 5'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester select.
// Ports:
//   req  - request vector, one bit per channel
//   ptr  - channel where the search starts (last winner + 1)
//   gnt  - one-hot grant, all zero when nothing requests
module rr_arbiter #(
  parameter int NCH = 2,
  parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt
);

  int            pos;
  logic [PW-1:0] idx;
  logic          found;

  // Walk channels ptr, ptr+1, ... wrapping at NCH; first requester wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NCH) pos = pos - NCH;
      idx = pos[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port byte-wide RAM arbiter shared by one instruction fetch port
// and NCH load/store channels. A winner is picked in IDLE, its request is
// latched, then ISSUE walks mem_a over K consecutive bytes. Reads take one
// extra DRAIN cycle for the last byte to return; RESP pulses done.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   rdy                - global enable, low freezes the transaction
//   mem_a/dout/wr/din  - byte RAM port, read data arrives one cycle late
//   io_full            - stalls accesses into the IO window
//   if_req/addr/done/line, flush - fetch port, flush aborts a fetch
//   ls_req/we/size/signed/addr/wdata/done, ls_rdata - load/store channels
//   busy               - high whenever not in IDLE
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int LINE_BYTES = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [7:0]              mem_din,
  input  logic                    io_full,
  output logic [31:0]             mem_a,
  output logic [7:0]              mem_dout,
  output logic                    mem_wr,
  input  logic                    if_req,
  input  logic [31:0]             if_addr,
  input  logic                    flush,
  output logic                    if_done,
  output logic [8*LINE_BYTES-1:0] if_line,
  input  logic [NCH-1:0]          ls_req,
  input  logic [NCH-1:0]          ls_we,
  input  logic [2*NCH-1:0]        ls_size,
  input  logic [NCH-1:0]          ls_signed,
  input  logic [32*NCH-1:0]       ls_addr,
  input  logic [32*NCH-1:0]       ls_wdata,
  output logic [NCH-1:0]          ls_done,
  output logic [31:0]             ls_rdata,
  output logic                    busy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CB = (LINE_BYTES > 4) ? LINE_BYTES : 4;  // capture bytes
  localparam int IW = $clog2(CB);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [1:0]    size;
    logic          we;
    logic          sgn;
    logic          fetch;
    logic [PW-1:0] ch;
  } txn_t;

  state_t               state, state_nx;
  txn_t                 txn, gtxn;
  logic [4:0]           cnt, len, glen;
  logic [PW-1:0]        rr_ptr, gnt_idx;
  logic [SW-1:0]        starve_cnt;
  logic [NCH-1:0]       mask_ls, req_eff, gnt, ch_oh;
  logic                 mask_if, if_pend;
  logic                 fetch_win, data_win, stall, abort, last;
  logic                 cap_vld;
  logic [IW-1:0]        cap_idx;
  logic [CB-1:0][7:0]   cap_buf;
  logic [3:0][7:0]      wbytes;
  logic [31:0]          ld_val;

  logic [NCH-1:0][31:0] addr_a, wdata_a;
  logic [NCH-1:0][1:0]  size_a;

  assign addr_a  = ls_addr;
  assign wdata_a = ls_wdata;
  assign size_a  = ls_size;

  // ---------------------------------------------------------------- arbitration
  // The requester served last is masked for one cycle so a req that is
  // still high while it drops is not re-granted.
  assign req_eff   = ls_req & ~mask_ls;
  assign if_pend   = if_req & ~mask_if;
  assign fetch_win = if_pend && !flush &&
                     (!(|req_eff) || (starve_cnt >= SW'(STARVE_MAX)));
  assign data_win  = (|req_eff) && !fetch_win;

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_rr (
    .req (req_eff),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++)
      if (gnt[i]) gnt_idx = PW'(i);
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) ch_oh[i] = (txn.ch == PW'(i));
  end

  always_comb begin
    gtxn = '0;
    glen = '0;
    if (fetch_win) begin
      gtxn.addr  = if_addr;
      gtxn.fetch = 1'b1;
      glen       = 5'(LINE_BYTES);
    end else begin
      gtxn.addr  = addr_a[gnt_idx];
      gtxn.wdata = wdata_a[gnt_idx];
      gtxn.size  = size_a[gnt_idx];
      gtxn.we    = ls_we[gnt_idx];
      gtxn.sgn   = ls_signed[gnt_idx];
      gtxn.ch    = gnt_idx;
      glen       = size_len(size_a[gnt_idx]);
    end
  end

  // ---------------------------------------------------------------- transfer
  assign stall  = (txn.addr[IO_BIT+1:IO_BIT] == IO_SEL) && io_full;
  assign abort  = txn.fetch && flush;
  assign last   = (cnt == len - 5'd1);
  assign wbytes = txn.wdata;

  always_comb begin
    case (txn.size)
      SZ_BYTE: ld_val = {{24{txn.sgn & cap_buf[0][7]}}, cap_buf[0]};
      SZ_HALF: ld_val = {{16{txn.sgn & cap_buf[1][7]}}, cap_buf[1], cap_buf[0]};
      default: ld_val = {cap_buf[3], cap_buf[2], cap_buf[1], cap_buf[0]};
    endcase
  end

  // ---------------------------------------------------------------- FSM comb
  always_comb begin
    state_nx = state;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if_done  = 1'b0;
    if_line  = '0;
    ls_done  = '0;
    ls_rdata = '0;
    busy     = (state != IDLE);
    case (state)
      IDLE: if (fetch_win || data_win) state_nx = ISSUE;
      ISSUE: begin
        mem_a = txn.addr + 32'(cnt);
        if (txn.we) begin
          mem_dout = wbytes[cnt[1:0]];
          mem_wr   = rdy && !stall;
        end
        if (abort)               state_nx = IDLE;
        else if (!stall && last) state_nx = txn.we ? RESP : DRAIN;
      end
      DRAIN: state_nx = abort ? IDLE : RESP;
      RESP: begin
        state_nx = IDLE;
        if (txn.fetch) begin
          if_done = rdy && !flush;
          if (if_done) if_line = cap_buf[LINE_BYTES-1:0];
        end else begin
          ls_done  = rdy ? ch_oh : '0;
          ls_rdata = ld_val;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      txn        <= '0;
      cnt        <= '0;
      len        <= '0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
      mask_ls    <= '0;
      mask_if    <= 1'b0;
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
      cap_buf    <= '0;
    end else begin
      // The byte for the address issued last cycle is on mem_din now. It is
      // absorbed even while rdy is low, since the RAM will have moved on to
      // the held address by the time rdy returns.
      if (cap_vld) cap_buf[cap_idx] <= mem_din;
      if (rdy) begin
        state   <= state_nx;
        cap_vld <= (state == ISSUE) && !txn.we && !stall && !abort;
        cap_idx <= cnt[IW-1:0];
        if (state == ISSUE && state_nx == ISSUE)
          cnt <= stall ? cnt : cnt + 5'd1;
        else
          cnt <= '0;
        mask_ls <= (state == RESP && !txn.fetch) ? ch_oh : '0;
        mask_if <= (state == RESP) && txn.fetch;
        if (state == IDLE && (fetch_win || data_win)) begin
          txn <= gtxn;
          len <= glen;
          if (fetch_win) begin
            starve_cnt <= '0;
          end else begin
            rr_ptr <= (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
            if (if_pend && starve_cnt < SW'(STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
      end else begin
        cap_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: NCH=2, LINE_BYTES=8, STARVE_MAX=4, with a
// byte RAM model whose contents come from a fixed address map.
module tb_mem_arbiter;
  localparam int NCH = 2;
  localparam int LB  = 8;

  logic              clk = 1'b0;
  logic              rst, rdy, io_full, if_req, flush;
  logic [7:0]        mem_din = 8'h00;
  logic [31:0]       mem_a, if_addr, ls_rdata;
  logic [7:0]        mem_dout;
  logic              mem_wr, if_done, busy;
  logic [8*LB-1:0]   if_line;
  logic [NCH-1:0]    ls_req, ls_we, ls_signed, ls_done;
  logic [2*NCH-1:0]  ls_size;
  logic [32*NCH-1:0] ls_addr, ls_wdata;

  int n_chk = 0, n_err = 0, cyc = 0;
  logic [7:0] wr_log[$];
  int exp_seq[6] = '{0, 1, 0, 1, 9, 0};

  mem_arbiter #(.NCH(NCH), .LINE_BYTES(LB), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .io_full(io_full),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .if_req(if_req), .if_addr(if_addr), .flush(flush), .if_done(if_done),
    .if_line(if_line), .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size),
    .ls_signed(ls_signed), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    case (a)
      32'h1000: ram_rd = 8'h11;
      32'h1001: ram_rd = 8'h22;
      32'h1002: ram_rd = 8'h33;
      32'h1003: ram_rd = 8'h44;
      32'h0020: ram_rd = 8'h80;
      32'h0021: ram_rd = 8'h34;
      32'h0022: ram_rd = 8'h92;
      default:  ram_rd = (a[31:4] == 28'h20) ? {4'hA, a[3:0]} : (a[7:0] ^ 8'h5A);
    endcase
  endfunction

  always @(posedge clk) mem_din <= ram_rd(mem_a);
  always @(posedge clk) if (mem_wr) wr_log.push_back(mem_dout);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one load/store on channel ch; lat = done cycle - arbitration cycle.
  task automatic ls_op(input int ch, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat,
                       output logic [31:0] rd);
    int a;
    bit seen;
    @(posedge clk); #1;
    ls_we[ch] = we; ls_size[ch*2 +: 2] = sz; ls_signed[ch] = sg;
    ls_addr[ch*32 +: 32] = addr; ls_wdata[ch*32 +: 32] = wd;
    ls_req[ch] = 1'b1;
    a = cyc; seen = 1'b0; lat = -1; rd = '0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (ls_done[ch]) begin
        seen = 1'b1; lat = cyc - a; rd = ls_rdata;
      end
    end
    chk("ls_timeout", seen, 1);
    @(posedge clk); #1;
    ls_req[ch] = 1'b0;
  endtask

  int          lat, w0, stall_n;
  logic [31:0] rd, wword;
  bit          seen, any_wr, dn;
  int          seq[$];
  logic [63:0] line;

  initial begin
    rst = 1'b1; rdy = 1'b1; io_full = 1'b0; if_req = 1'b0; flush = 1'b0;
    if_addr = '0; ls_req = '0; ls_we = '0; ls_signed = '0; ls_size = '0;
    ls_addr = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem", {mem_a, mem_dout, mem_wr}, 0);
    chk("rst_done", {ls_done, if_done}, 0);
    chk("rst_rdata", ls_rdata, 0);
    chk("rst_line", if_line, 0);

    // word load, little-endian assembly, A+6
    ls_op(0, 1'b0, 2'b10, 1'b0, 32'h1000, 0, lat, rd);
    chk("lw_data", rd, 32'h44332211);
    chk("lw_lat", lat, 6);

    ls_op(1, 1'b0, 2'b00, 1'b1, 32'h20, 0, lat, rd);
    chk("lb_data", rd, 32'hFFFFFF80);
    chk("lb_lat", lat, 3);

    // unsigned byte with flush held high: data traffic ignores flush
    flush = 1'b1;
    ls_op(1, 1'b0, 2'b00, 1'b0, 32'h20, 0, lat, rd);
    flush = 1'b0;
    chk("lbu_data", rd, 32'h00000080);
    chk("lbu_lat", lat, 3);

    // misaligned halfword
    ls_op(0, 1'b0, 2'b01, 1'b1, 32'h21, 0, lat, rd);
    chk("lh_data", rd, 32'hFFFF9234);
    chk("lh_lat", lat, 4);
    ls_op(0, 1'b0, 2'b01, 1'b0, 32'h21, 0, lat, rd);
    chk("lhu_data", rd, 32'h00009234);

    // IO store with io_full for 3 cycles after the first byte
    w0 = wr_log.size(); stall_n = 0;
    fork
      ls_op(0, 1'b1, 2'b10, 1'b0, 32'h30000, 32'hAABBCCDD, lat, rd);
      begin
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          @(negedge clk);
          if (mem_wr) seen = 1'b1;
        end
        @(posedge clk); #1 io_full = 1'b1;
        repeat (3) begin
          @(negedge clk);
          if (!mem_wr && mem_a != 0) stall_n++;
          @(posedge clk);
        end
        #1 io_full = 1'b0;
        @(negedge clk);
        chk("sw_resume", mem_wr, 1);
      end
    join
    chk("sw_stall", stall_n, 3);
    chk("sw_lat", lat, 8);
    chk("sw_nbytes", wr_log.size() - w0, 4);
    wword = (wr_log.size() - w0 == 4) ?
            {wr_log[w0+3], wr_log[w0+2], wr_log[w0+1], wr_log[w0]} : '0;
    chk("sw_bytes", wword, 32'hAABBCCDD);

    // rdy low two cycles in the middle of a word load
    fork
      ls_op(0, 1'b0, 2'b10, 1'b0, 32'h1000, 0, lat, rd);
      begin
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join
    chk("rdy_data", rd, 32'h44332211);
    chk("rdy_lat", lat, 8);

    // fetch flushed while byte 3 is on the bus
    @(posedge clk); #1 if_addr = 32'h200; if_req = 1'b1;
    seen = 1'b0; any_wr = 1'b0; dn = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      any_wr |= mem_wr;
      if (mem_a == 32'h202) seen = 1'b1;
    end
    chk("fl_reach", seen, 1);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("fl_byte3", mem_a, 32'h203);
    any_wr |= mem_wr;
    @(posedge clk); #1 flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("fl_idle", busy, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dn |= if_done;
      any_wr |= mem_wr;
    end
    chk("fl_nodone", dn, 0);
    chk("fl_nowr", any_wr, 0);
    ls_op(1, 1'b0, 2'b00, 1'b1, 32'h20, 0, lat, rd);
    chk("fl_next_data", rd, 32'hFFFFFF80);
    chk("fl_next_lat", lat, 3);

    // reset in the middle of a halfword store
    @(posedge clk); #1;
    ls_we[1] = 1'b1; ls_size[3:2] = 2'b01; ls_addr[63:32] = 32'h50;
    ls_wdata[63:32] = 32'h1234; ls_req[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("sh_started", mem_wr, 1);
    @(posedge clk); #1 rst = 1'b1; ls_req = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rs_busy", busy, 0);
    chk("rs_mem", {mem_a, mem_dout, mem_wr}, 0);
    dn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dn |= (|ls_done);
    end
    chk("rs_nodone", dn, 0);

    // round robin with a starving fetch
    ls_we = '0; ls_signed = '0; ls_size = 4'b1010;
    ls_addr = {32'h1000, 32'h1000}; if_addr = 32'h200;
    line = '0;
    @(posedge clk); #1 ls_req = 2'b11; if_req = 1'b1;
    for (int k = 0; k < 200 && seq.size() < 6; k++) begin
      @(negedge clk);
      if (ls_done[0]) seq.push_back(0);
      if (ls_done[1]) seq.push_back(1);
      if (if_done) begin
        seq.push_back(9);
        line = if_line;
        @(posedge clk); #1 if_req = 1'b0;
      end
    end
    @(posedge clk); #1 ls_req = '0;
    for (int k = 0; k < 40 && busy; k++) @(negedge clk);
    chk("rr_count", seq.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_seq%0d", i), (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
    chk("if_line", line, 64'hA7A6A5A4A3A2A1A0);
    chk("rr_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NCH, default 2: number of load/store channels, range 1..8.
REQ-002 SHALL have parameter LINE_BYTES, default 4: fetch line length in bytes, range 1..16.
REQ-003 SHALL have parameter STARVE_MAX, default 4: the maximum number of consecutive data grants allowed while if_req is pending.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; one clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state freezes.
- mem_din  in  8  RAM read byte, one cycle after mem_a.
- io_full  in  1  IO buffer full.
- mem_a  out  32  RAM byte address.
- mem_dout  out  8  RAM write byte.
- mem_wr  out  1  write strobe.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  32  fetch start address.
- flush  in  1  abort fetch.
- if_done  out  1  one-cycle fetch completion pulse.
- if_line  out  8*LINE_BYTES  fetched line, little-endian, valid with if_done.
- ls_req  in  NCH  per-channel request; held until done.
- ls_we  in  NCH  1 = store.
- ls_size  in  2*NCH  00 = byte, 01 = half, 10 or 11 = word.
- ls_signed  in  NCH  sign-extend loads.
- ls_addr  in  32*NCH  byte address.
- ls_wdata  in  32*NCH  store data.
- ls_done  out  NCH  one-cycle completion pulse.
- ls_rdata  out  32  load result, valid with ls_done.
- busy  out  1  transaction in progress.

Function
REQ-005 SHALL be built around a state machine with states IDLE, ISSUE, DRAIN and RESP.
REQ-006 SHALL arbitrate only in IDLE. Any ls_req beats if_req, except after STARVE_MAX consecutive data grants with if_req pending, when fetch wins. The counter clears on every fetch grant.
REQ-007 SHALL choose among data channels round-robin, starting the search at (last granted + 1) mod NCH.
REQ-008 SHALL latch the winner's addr, size, we, wdata and signed in arbitration cycle A, then move to ISSUE.
REQ-009 SHALL use a transfer length K = LINE_BYTES for fetch, and 1, 2 or 4 for data per ls_size.
REQ-010 SHALL, in ISSUE, drive mem_a = base + i (mod 2^32) for i = 0..K-1, one byte per cycle. Misaligned addresses are legal.
REQ-011 SHALL, for stores, drive mem_wr = 1 and mem_dout = wdata byte i during each ISSUE cycle.
REQ-012 SHALL, for reads, capture mem_din into byte i-1 at each edge. DRAIN captures byte K-1.
REQ-013 SHALL pulse done in RESP: cycle A+K+1 for writes, A+K+2 for reads (rdy high, no stall).
REQ-014 SHALL zero-extend byte and half loads, or sign-extend them from bit 7/15 when signed is set.
REQ-015 SHALL mask the just-served requester's req for the cycle after RESP.
REQ-016 SHALL stall when io_full = 1 and the latched addr[17:16] = 2'b11: mem_wr = 0, byte counter held, resume when io_full falls.
REQ-017 SHALL freeze all state while rdy = 0, with mem_wr forced to 0.
REQ-018 SHALL abort an active fetch on flush = 1: the next state is IDLE, with no if_done.
REQ-019 SHALL ignore flush for data transactions.
REQ-020 SHALL not grant a fetch in a cycle where flush = 1.
REQ-021 SHALL keep mem_a = 0, mem_dout = 0 and mem_wr = 0 outside ISSUE.
REQ-022 SHALL drive busy high in every state except IDLE.

Reset
REQ-023 SHALL, on rst high at a clock edge, set the state to IDLE and clear all counters, the round-robin pointer, the starvation count and the capture registers.
REQ-024 SHALL, after reset, hold mem_a, mem_dout, mem_wr, if_done, if_line, ls_done, ls_rdata and busy at 0.
REQ-025 SHALL abandon any in-flight transaction on reset mid-operation, with no done pulse.
REQ-026 SHALL take rst priority over rdy.

Structure
REQ-027 SHALL place the size encodings, the IO address bits (17:16 = 2'b11) and the state encodings in the shared defines file.
REQ-028 SHALL implement round-robin selection as sub-module rr_arbiter (parameter NCH; req vector and pointer in; one-hot grant out).

Verification
REQ-029 SHALL cover these directed scenarios:
- ch0 LW at 0x1000, RAM bytes 11 22 33 44 -> ls_rdata 0x44332211; ls_done[0] in cycle A+6.
- ch1 LB signed at 0x20, byte 0x80 -> ls_rdata 0xFFFFFF80; the LBU case -> 0x00000080.
- ch0 and ch1 requesting continuously, NCH = 2 -> grants alternate 0, 1, 0, 1. With if_req pending, the fetch is granted after 4 data grants.
- SW 0xAABBCCDD to 0x30000 with io_full high for 3 cycles after the first byte -> mem_wr held 0 for 3 cycles; byte order DD CC BB AA; ls_done at A+8.
- Fetch with LINE_BYTES = 8, flush asserted at byte 3 -> no if_done; next arbitration in IDLE; mem_wr never high.
- rdy low for 2 cycles mid-LW -> done delayed exactly 2 cycles. Reset mid-SH -> no ls_done, all outputs 0.
